// File: rtl/bias_bank_sel_pipe.sv
// Registered bias-bank selector: a bank pointer (load / step / zero-mode) picks one
// N_adder_tree-lane bias vector per cycle; out-of-range pointer codes yield an all-zero bias.
module bias_bank_sel_pipe #(
    parameter int unsigned N_adder_tree = 16,
    parameter int unsigned BIAS_W       = 18,
    parameter int unsigned N_BANKS      = 4,
    parameter int unsigned SEL_W        = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [N_BANKS*N_adder_tree*BIAS_W-1:0] i_bias_bus,
    input  logic                              i_load,
    input  logic [SEL_W-1:0]                  i_sel,
    input  logic                              i_next,
    input  logic                              i_zero,
    output logic [N_adder_tree*BIAS_W-1:0]    o_bias,
    output logic                              o_bias_valid,
    output logic [SEL_W-1:0]                  o_bank_idx,
    output logic                              o_wrap
);

    localparam int unsigned      VW       = N_adder_tree * BIAS_W;
    localparam logic [SEL_W-1:0] LastBank = SEL_W'(N_BANKS - 1);

    logic [SEL_W-1:0] r_ptr;
    logic             r_armed;
    logic             r_wrap;
    logic [VW-1:0]    r_bias;
    logic             r_bias_valid;

    logic [VW-1:0]    w_bank_vec;
    logic             w_in_range;

    // Decoding by matching codes keeps every unused code at zero bias without a width-fragile compare.
    always_comb begin
        w_bank_vec = '0;
        w_in_range = 1'b0;
        for (int unsigned k = 0; k < N_BANKS; k++) begin
            if (r_ptr == SEL_W'(k)) begin
                w_bank_vec = i_bias_bus[k*VW +: VW];
                w_in_range = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr        <= '0;
            r_armed      <= 1'b0;
            r_wrap       <= 1'b0;
            r_bias       <= '0;
            r_bias_valid <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_zero) begin
                r_ptr   <= '1;
                r_armed <= 1'b1;
            end else if (i_load) begin
                r_ptr   <= i_sel;
                r_armed <= 1'b1;
            end else if (i_next && w_in_range) begin
                // Zero mode (out-of-range pointer) ignores next entirely.
                if (r_ptr == LastBank) begin
                    r_ptr  <= '0;
                    r_wrap <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + SEL_W'(1);
                end
            end
            r_bias       <= w_bank_vec;
            r_bias_valid <= r_armed & w_in_range;
        end
    end

    assign o_bias       = r_bias;
    assign o_bias_valid = r_bias_valid;
    assign o_bank_idx   = r_ptr;
    assign o_wrap       = r_wrap;

endmodule
